// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [MD_XLEN-1:0] INT_MIN  = {1'b1, {(MD_XLEN-1){1'b0}}};
  localparam logic [MD_XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic rs1_is_signed(op_e o);
    return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic rs2_is_signed(op_e o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff_lo;

  assign trial   = {rem_i, bit_i};
  // rem_i < divisor keeps a successful difference inside XLEN bits.
  assign diff_lo = trial[XLEN-1:0] - divisor_i;
  assign q_o     = (trial >= {1'b0, divisor_i});
  assign rem_o   = q_o ? diff_lo : trial[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide.
// Build option MULDIV_FAST_MUL_EN replaces the multiply iterations with one product.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  op_e             op_in;
  logic            sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix;

  assign op_in    = op_e'(op);
  assign sa       = rs1_is_signed(op_in) & rs1[XLEN-1];
  assign sb       = rs2_is_signed(op_in) & rs2[XLEN-1];
  assign a_mag    = sa ? -rs1 : rs1;
  assign b_mag    = sb ? -rs2 : rs2;
  assign div_zero = (rs2 == '0);
  assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (rs1 == INT_MIN) && (rs2 == ALL_ONES);

  // acc holds {high, low}: multiplier/product for MUL*, {remainder, dividend/quotient} for DIV*.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .divisor_i (opnd_q),
    .bit_i     (acc_q[XLEN-1]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign div_fix  = neg_q ? -div_sel : div_sel;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
  assign a_ext     = {{XLEN{rs1_is_signed(op_in) & rs1[XLEN-1]}}, rs1};
  assign b_ext     = {{XLEN{rs2_is_signed(op_in) & rs2[XLEN-1]}}, rs2};
  assign fast_prod = a_ext * b_ext;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            state_d = CALC;
            op_d    = op_in;
            cnt_d   = CNT_W'(XLEN);
            if (op[2]) begin
              acc_d  = {{XLEN{1'b0}}, a_mag};
              opnd_d = b_mag;
              neg_d  = op[1] ? sa : (sa ^ sb);
              if (div_zero || div_ovf) begin
                state_d  = DONE;
                if (div_zero) result_d = op[1] ? rs1 : ALL_ONES;
                else          result_d = op[1] ? '0 : INT_MIN;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc_d   = fast_prod;
              neg_d   = 1'b0;
              state_d = FIX;
`else
              acc_d   = {{XLEN{1'b0}}, b_mag};
              opnd_d  = a_mag;
              neg_d   = sa ^ sb;
`endif
            end
          end
        end
        CALC: begin
          if (op_q[2]) acc_d = {step_rem, acc_q[XLEN-2:0], step_q};
          else         acc_d = {mul_sum, acc_q[XLEN-1:1]};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
        FIX: begin
          if (op_q[2])               result_d = div_fix;
          else if (op_q == OP_MUL)   result_d = prod_fix[XLEN-1:0];
          else                       result_d = prod_fix[2*XLEN-1:XLEN];
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, special divides, flush, reset, start-while-busy.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current (negedge) cycle 0 and step to cycle 1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rs1 = ~a; rs2 = ~b; op = ~o;
  endtask

  // Called in cycle 1; returns in the done cycle (or after the bound).
  task automatic wait_done(input string tag, input logic [31:0] exp, input int lat);
    int  c = 1;
    bit  busy_ok = 1'b1;
    while (!done && c < 60) begin
      if (busy !== (c < lat)) busy_ok = 1'b0;
      @(negedge clk);
      c++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    check({tag, "_lat"}, c, lat);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_res"}, result, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(o, a, b);
    wait_done(tag, exp, lat);
  endtask

  initial begin
    int dones;
    int c;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; rs1 = '0; rs2 = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each op starts in the previous op's done cycle.
    run_op("mul",     3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mul_b",   3'b000, 32'h1234_5678, 32'h10,       32'h2345_6780, MUL_LAT);
    run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulh",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu_b", 3'b011, 32'h8000_0000, 32'd2,        32'h0000_0001, MUL_LAT);
    run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
    run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
    run_op("divu",    3'b101, 32'd100,      32'd7,         32'd14,        DIV_LAT);
    run_op("remu",    3'b111, 32'd100,      32'd7,         32'd2,         DIV_LAT);
    run_op("div_neg", 3'b100, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, DIV_LAT);
    run_op("rem_neg", 3'b110, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, DIV_LAT);
    run_op("divu_z",  3'b101, 32'd100,      32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_z",   3'b110, 32'd100,      32'd0,         32'd100,       1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    @(negedge clk);

    // Flush in cycle 10 of a DIV; prior result is 0 from rem_ovf.
    issue(3'b100, 32'd1000, 32'd3);
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("flush_busy_c10", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_c11", {31'd0, busy}, 32'd0);
    check("flush_done_c11", {31'd0, done + dones}, 32'd0);
    check("flush_hold", result, 32'd0);
    run_op("after_flush", 3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT);
    @(negedge clk);

    // flush and start together in IDLE: start dropped.
    op = 3'b101; rs1 = 32'd9; rs2 = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    check("flush_start_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("flush_start_hold", result, 32'd2);

    // Asynchronous reset mid-CALC.
    issue(3'b101, 32'd50, 32'd5);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start held high while busy with different operands: only the first op runs.
    op = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    op = 3'b101; rs1 = 32'd1; rs2 = 32'd1;
    c = 1;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("hold_lat", c, MUL_LAT);
    check("hold_res", result, 32'hFFFF_FFEB);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("hold_single_done", dones, 0);
    check("hold_result_kept", result, 32'hFFFF_FFEB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
